// File: rtl/dual_port_ram.sv
// ---------------------------------------------------------------------------
// dual_port_ram
//   Simple dual-port synchronous RAM used as the storage array of the byte
//   FIFO. Port A is read-only with a registered output (1-cycle latency).
//   Port B is write-only. Both ports share one clock and are serviced every
//   cycle independently.
//
//   Reset is synchronous and active-low. It clears only the port A output
//   register. Memory contents survive reset, and a port B write issued
//   during reset is still performed.
//
//   Optional feature macro: WRITE_FORWARD_EN
//     undefined (default): same-address read/write collisions are
//                          read-first, so dout_a gets the old word.
//     defined            : collisions are write-first, so dout_a gets din_b.
// ---------------------------------------------------------------------------
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  we_a,
  input  logic                  en_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  we_b,
  input  logic                  en_b,
  input  logic                  reset
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Port A only reads. A read fires when port A is enabled and its write
  // enable is low; we_a never modifies memory.
  logic rd_fire;
  assign rd_fire = en_a & ~we_a;

  // The FIFO ties en_b low while writing, so en_b must not gate writes. It is
  // accepted only for interface compatibility and is deliberately unused.
  logic unused_en_b;
  assign unused_en_b = en_b;

`ifdef WRITE_FORWARD_EN
  // A collision is a same-address read and write in the same cycle.
  logic collide;
  assign collide = we_b & (addr_a == addr_b);
`endif

  // Port B write: qualified by we_b only, and independent of reset.
  // NOTE: the array has no reset so it maps onto block RAM; clearing it would
  // force thousands of flops. Sequential state always uses non-blocking (<=)
  // so every reader sees the pre-edge value.
  always_ff @(posedge clock) begin
    if (we_b) begin
      mem[addr_b] <= din_b;
    end
  end

  // Port A registered read. Reset takes priority over the read. If the read
  // is disabled, the output register holds its value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dout_a <= '0;
    end else if (rd_fire) begin
`ifdef WRITE_FORWARD_EN
      if (collide) begin
        dout_a <= din_b;
      end else begin
        dout_a <= mem[addr_a];
      end
`else
      dout_a <= mem[addr_a];
`endif
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// ---------------------------------------------------------------------------
// tb_dual_port_ram
//   Self-checking bench for dual_port_ram (DATA_WIDTH=8, ADDR_WIDTH=13).
//   Each cycle's expected dout_a is computed from a reference memory model
//   when the stimulus is driven. It is pushed to a queue, then popped and
//   compared just after the rising edge that produces it.
//   Defining WRITE_FORWARD_EN switches the model to write-first collisions.
// ---------------------------------------------------------------------------
module tb_dual_port_ram;

  localparam int DW = 8;
  localparam int AW = 13;
  localparam logic [AW-1:0] TOP_ADDR = '1;

`ifdef WRITE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] dout_a;
  logic          we_a;
  logic          en_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] din_b;
  logic          we_b;
  logic          en_b;

  dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock  (clock),
    .addr_a (addr_a),
    .dout_a (dout_a),
    .we_a   (we_a),
    .en_a   (en_a),
    .addr_b (addr_b),
    .din_b  (din_b),
    .we_b   (we_b),
    .en_b   (en_b),
    .reset  (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model and scoreboard.
  bit   [DW-1:0] mem_model [int];
  logic [DW-1:0] dout_model;
  logic [DW-1:0] exp_q [$];
  string         tag_q [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle. The task drives the inputs on the falling edge, predicts
  // dout_a, advances the model, then compares just after the rising edge.
  task automatic step(input string tag, input logic rst_v,
                      input logic ena, input logic wea, input logic [AW-1:0] aa,
                      input logic web, input logic enb, input logic [AW-1:0] ab,
                      input logic [DW-1:0] db);
    logic [DW-1:0] exp;
    @(negedge clock);
    reset  = rst_v;
    en_a   = ena;
    we_a   = wea;
    addr_a = aa;
    we_b   = web;
    en_b   = enb;
    addr_b = ab;
    din_b  = db;

    if (!rst_v)                           exp = '0;
    else if (ena && !wea) begin
      if (FWD && web && (aa == ab))       exp = db;
      else                                exp = mem_model[int'(aa)];
    end else                              exp = dout_model;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    dout_model = exp;
    if (web) mem_model[int'(ab)] = db;

    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0x%02h expected an entry", tag, dout_a);
    end else begin
      string t;
      logic [DW-1:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, dout_a, e);
    end
  endtask

  // Shorthands for common cycles.
  task automatic wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(tag, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a);
    step(tag, 1'b1, 1'b1, 1'b0, a, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b0; en_a = 1'b0; we_a = 1'b0; addr_a = '0;
    we_b = 1'b0; en_b = 1'b0; addr_b = '0; din_b = '0;
    dout_model = '0;

    // The output register must come out of reset cleared.
    step("por_reset0", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    step("por_reset1", 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Test 1: with dout_a at 0xA5, reset clears it. A write issued during
    // reset still lands, and memory survives reset.
    wr("t1_wr3", 13'd3, 8'hA5);
    rd("t1_rd3", 13'd3);
    step("t1_reset", 1'b0, 1'b1, 1'b0, 13'd3, 1'b1, 1'b1, 13'd4, 8'h5A);
    rd("t1_mem3_kept", 13'd3);
    rd("t1_wr_in_reset", 13'd4);

    // Test 2: the write goes through with en_b low, and reads back after one cycle.
    step("t2_wr5", 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 13'd5, 8'h3C);
    rd("t2_rd5", 13'd5);

    // Test 3: en_a low holds dout_a while addr_a moves.
    wr("t3_wr6", 13'd6, 8'h77);
    step("t3_hold", 1'b1, 1'b0, 1'b0, 13'd6, 1'b0, 1'b0, '0, '0);
    step("t3_hold2", 1'b1, 1'b0, 1'b0, 13'd6, 1'b0, 1'b0, '0, '0);
    rd("t3_rd6", 13'd6);

    // Test 4: same-address collision, read-first unless forwarding.
    wr("t4_wr9", 13'd9, 8'h11);
    step("t4_collide", 1'b1, 1'b1, 1'b0, 13'd9, 1'b1, 1'b0, 13'd9, 8'h22);
    rd("t4_rd9_new", 13'd9);

    // Test 5: address boundaries with no aliasing.
    wr("t5_wr_top", TOP_ADDR, 8'hFF);
    wr("t5_wr_zero", 13'd0, 8'h01);
    rd("t5_rd_top", TOP_ADDR);
    rd("t5_rd_zero", 13'd0);
    rd("t5_rd_top2", TOP_ADDR);

    // Test 6: we_a is a hold and never writes memory.
    step("t6_we_a_hold", 1'b1, 1'b1, 1'b1, 13'd0, 1'b0, 1'b0, '0, '0);
    rd("t6_rd_zero", 13'd0);

    // Randomised traffic over a small window. Every location in it is
    // written first, so no read depends on power-up content.
    for (int i = 0; i < 32; i++) wr("rnd_fill", AW'(100 + i), DW'($urandom));
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] ra, wa;
      ra = AW'(100 + $urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? ra : AW'(100 + $urandom_range(0, 31));
      step("rnd", ($urandom_range(0, 19) != 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, ra, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, wa, DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
